// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, command field helpers and the
// read_commands FSM state type.
package cpu_pkg;

   localparam int OPC_W = 4;
   localparam int CMD_W = 14;

   localparam logic [OPC_W-1:0] OPC_NOP   = 4'h0;
   localparam logic [OPC_W-1:0] OPC_LOAD  = 4'h1;
   localparam logic [OPC_W-1:0] OPC_STORE = 4'h2;
   localparam logic [OPC_W-1:0] OPC_ADD   = 4'h3;
   localparam logic [OPC_W-1:0] OPC_JUMP  = 4'h8;
   localparam logic [OPC_W-1:0] OPC_HALT  = 4'hF;

   typedef enum logic {ST_RUN, ST_HALTED} rc_state_t;

   // Opcode lives in the MSBs of a command word, operand in the remainder
   function automatic logic [OPC_W-1:0] cmd_opcode_of(input logic [CMD_W-1:0] cmd);
      return cmd[CMD_W-1 -: OPC_W];
   endfunction

   function automatic logic [CMD_W-OPC_W-1:0] cmd_operand_of(input logic [CMD_W-1:0] cmd);
      return cmd[CMD_W-OPC_W-1:0];
   endfunction

   function automatic logic is_halt(input logic [OPC_W-1:0] opc);
      return opc == OPC_HALT;
   endfunction

endpackage

// File: rtl/read_commands_if.sv
// Write side (ROM-read stage) and read side (execute stage) of the command
// buffer, bundled so the producer/consumer view is one port.
interface read_commands_if #(
   parameter int DATA_W = 14,
   parameter int ADDR_W = 12,
   parameter int OPC_W  = 4
);
   logic                    comm_write;
   logic [DATA_W-1:0]       data_in;
   logic [ADDR_W-1:0]       addr_in;
   logic                    pause_READ;
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [OPC_W-1:0]        cmd_opcode;
   logic [DATA_W-OPC_W-1:0] cmd_operand;
   logic [ADDR_W-1:0]       cmd_addr;

   modport master (
      output comm_write, data_in, addr_in, cmd_ready,
      input  pause_READ, cmd_valid, cmd_opcode, cmd_operand, cmd_addr
   );

   modport slave (
      input  comm_write, data_in, addr_in, cmd_ready,
      output pause_READ, cmd_valid, cmd_opcode, cmd_operand, cmd_addr
   );
endinterface

// File: rtl/cmd_buf_mem.sv
// Command storage: register array with one synchronous write port and one
// asynchronous read port. No reset; validity is tracked by the owner.
module cmd_buf_mem #(
   parameter int W     = 26,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/read_commands.sv
// Command buffer between ROM-read and execute: circular queue with back-pressure,
// opcode/operand split of the head entry, and a HALT latch cleared by flush.
module read_commands
   import cpu_pkg::*;
#(
   parameter int DATA_W    = 14,
   parameter int ADDR_W    = 12,
   parameter int DEPTH     = 8,
   parameter int PAUSE_LVL = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   read_commands_if.slave         bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);

   localparam int PW    = $clog2(DEPTH);
   localparam int LW    = PW + 1;
   localparam int ENT_W = ADDR_W + DATA_W;

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [ENT_W-1:0] head;
   rc_state_t        state, state_next;
   logic             cmd_valid, pause, push, pop;

   cmd_buf_mem #(.W(ENT_W), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push && !flush),
      .waddr (wr_ptr),
      .wdata ({bus.addr_in, bus.data_in}),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // Handshake outputs depend only on registered level/state, never on
   // comm_write or cmd_ready, so no combinational path crosses the stage.
   always_comb begin
      state_next = state;
      cmd_valid  = 1'b0;
      pause      = 1'b1;
      case (state)
         ST_RUN: begin
            cmd_valid = (level != '0);
            pause     = (level >= LW'(PAUSE_LVL));
            if (cmd_valid && bus.cmd_ready && is_halt(head[DATA_W-1 -: OPC_W]))
               state_next = ST_HALTED;
         end
         ST_HALTED: ;
         default: state_next = ST_RUN;
      endcase
      if (flush) state_next = ST_RUN;
   end

   assign pop  = cmd_valid && bus.cmd_ready;
   assign push = bus.comm_write && ((level < LW'(DEPTH)) || pop);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_RUN;
      else       state <= state_next;
   end

   // Flush shares the reset path so that any same-cycle write or pop is lost
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         level <= level + LW'(push) - LW'(pop);
         if (bus.comm_write && !push) overflow <= 1'b1;
      end
   end

   assign bus.cmd_valid   = cmd_valid;
   assign bus.pause_READ  = pause;
   assign bus.cmd_opcode  = head[DATA_W-1 -: OPC_W];
   assign bus.cmd_operand = head[DATA_W-OPC_W-1:0];
   assign bus.cmd_addr    = head[ENT_W-1 -: ADDR_W];

endmodule

// File: tb/tb_read_commands.sv
// Self-checking bench for read_commands: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_read_commands;
   import cpu_pkg::*;

   localparam int DATA_W    = 14;
   localparam int ADDR_W    = 12;
   localparam int DEPTH     = 8;
   localparam int PAUSE_LVL = 6;
   localparam int LW        = $clog2(DEPTH) + 1;
   localparam int ENT_W     = ADDR_W + DATA_W;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic [LW-1:0] level;
   logic          overflow;

   read_commands_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) bus ();

   read_commands #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PAUSE_LVL(PAUSE_LVL)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .bus      (bus.slave),
      .level    (level),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ENT_W-1:0] q[$];
   bit               m_halted   = 1'b0;
   bit               m_ovf      = 1'b0;
   bit               model_live = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of {addr,data}; pops happen first so a full
   // buffer still accepts a write in a cycle where the head leaves.
   always @(posedge clk) begin
      logic [ENT_W-1:0] popped;
      bit               m_valid;
      model_live = 1'b1;
      if (reset || flush) begin
         q.delete();
         m_halted = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         m_valid = !m_halted && (q.size() > 0);
         if (m_valid && bus.cmd_ready) begin
            popped = q.pop_front();
            if (popped[DATA_W-1 -: OPC_W] == 4'hF) m_halted = 1'b1;
         end
         if (bus.comm_write) begin
            if (q.size() < DEPTH) q.push_back({bus.addr_in, bus.data_in});
            else                  m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      logic [ENT_W-1:0] exp_ent;
      bit               exp_valid;
      if (model_live) begin
         exp_valid = !m_halted && (q.size() > 0);
         check_output("level",      32'(level),          32'(q.size()));
         check_output("overflow",   32'(overflow),       32'(m_ovf));
         check_output("cmd_valid",  32'(bus.cmd_valid),  32'(exp_valid));
         check_output("pause_READ", 32'(bus.pause_READ),
                      32'(m_halted || (q.size() >= PAUSE_LVL)));
         if (exp_valid) begin
            exp_ent = q[0];
            check_output("cmd_opcode",  32'(bus.cmd_opcode),  32'(exp_ent[DATA_W-1 -: OPC_W]));
            check_output("cmd_operand", 32'(bus.cmd_operand), 32'(exp_ent[DATA_W-OPC_W-1:0]));
            check_output("cmd_addr",    32'(bus.cmd_addr),    32'(exp_ent[ENT_W-1 -: ADDR_W]));
         end
      end
   end

   task automatic apply_stimulus(input logic cw, input logic [DATA_W-1:0] d,
                                 input logic [ADDR_W-1:0] a, input logic rdy, input logic fl);
      bus.comm_write = cw;
      bus.data_in    = d;
      bus.addr_in    = a;
      bus.cmd_ready  = rdy;
      flush          = fl;
      @(negedge clk);
   endtask

   initial begin
      logic [DATA_W-1:0] d;
      bus.comm_write = 1'b0;
      bus.data_in    = '0;
      bus.addr_in    = '0;
      bus.cmd_ready  = 1'b0;
      reset          = 1'b1;
      repeat (2) @(negedge clk);
      check_output("rst_level", 32'(level),          32'd0);
      check_output("rst_valid", 32'(bus.cmd_valid),  32'd0);
      check_output("rst_pause", 32'(bus.pause_READ), 32'd0);
      check_output("rst_ovf",   32'(overflow),       32'd0);
      reset = 1'b0;

      // Single command, field split and pop
      apply_stimulus(1'b1, 14'h1ABC, 12'h010, 1'b0, 1'b0);
      check_output("first_valid",   32'(bus.cmd_valid),   32'd1);
      check_output("first_opcode",  32'(bus.cmd_opcode),  32'h6);
      check_output("first_operand", 32'(bus.cmd_operand), 32'h2BC);
      check_output("first_addr",    32'(bus.cmd_addr),    32'h010);
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
      check_output("first_pop_level", 32'(level), 32'd0);

      // Back-pressure threshold
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(1'b1, 14'h0100 + DATA_W'(i), 12'h100 + ADDR_W'(i), 1'b0, 1'b0);
         check_output("fill_level", 32'(level),          32'(i + 1));
         check_output("fill_pause", 32'(bus.pause_READ), 32'(i == 5));
      end
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
      check_output("unpause_level", 32'(level),          32'd5);
      check_output("unpause_pause", 32'(bus.pause_READ), 32'd0);

      // Full buffer: drop without pop, accept with pop
      for (int i = 0; i < 3; i++)
         apply_stimulus(1'b1, 14'h0200 + DATA_W'(i), 12'h200 + ADDR_W'(i), 1'b0, 1'b0);
      check_output("full_level", 32'(level), 32'd8);
      apply_stimulus(1'b1, 14'h0211, 12'h211, 1'b0, 1'b0);
      check_output("drop_level", 32'(level),    32'd8);
      check_output("drop_ovf",   32'(overflow), 32'd1);
      apply_stimulus(1'b1, 14'h0222, 12'h222, 1'b1, 1'b0);
      check_output("pushpop_level", 32'(level), 32'd8);
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);
      check_output("flush_level", 32'(level),    32'd0);
      check_output("flush_ovf",   32'(overflow), 32'd0);

      // HALT stops delivery until flush
      apply_stimulus(1'b1, 14'h3C05, 12'h020, 1'b0, 1'b0);
      apply_stimulus(1'b1, 14'h0001, 12'h021, 1'b0, 1'b0);
      check_output("halt_head_opc", 32'(bus.cmd_opcode), 32'hF);
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
      check_output("halted_valid", 32'(bus.cmd_valid),  32'd0);
      check_output("halted_pause", 32'(bus.pause_READ), 32'd1);
      check_output("halted_level", 32'(level),          32'd1);
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
      check_output("halted_hold", 32'(level), 32'd1);
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);
      check_output("unhalt_level", 32'(level),          32'd0);
      check_output("unhalt_pause", 32'(bus.pause_READ), 32'd0);
      check_output("unhalt_ovf",   32'(overflow),       32'd0);

      // Streaming across pointer wrap with toggling ready
      for (int i = 0; i < 20; i++) begin
         d = {4'h1, 10'(i * 37)};
         apply_stimulus(1'b1, d, 12'h300 + ADDR_W'(i), 1'(i % 3 != 0), 1'b0);
      end
      repeat (10) apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
      check_output("drain_level", 32'(level), 32'd0);

      // Flush with a same-cycle write discards that write
      for (int i = 0; i < 3; i++)
         apply_stimulus(1'b1, 14'h0AA0 + DATA_W'(i), 12'h040 + ADDR_W'(i), 1'b0, 1'b0);
      check_output("pre_flush_level", 32'(level), 32'd3);
      apply_stimulus(1'b1, 14'h2DEF, 12'h3FF, 1'b0, 1'b1);
      check_output("flushwr_level", 32'(level), 32'd0);
      apply_stimulus(1'b1, 14'h0123, 12'h055, 1'b0, 1'b0);
      check_output("after_flush_opc",  32'(bus.cmd_opcode),  32'h0);
      check_output("after_flush_opnd", 32'(bus.cmd_operand), 32'h123);
      check_output("after_flush_addr", 32'(bus.cmd_addr),    32'h055);
      apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);

      // Random traffic, including HALT opcodes and occasional flushes
      for (int i = 0; i < 400; i++) begin
         apply_stimulus(1'($urandom_range(3) != 0), DATA_W'($urandom), ADDR_W'($urandom),
                        1'($urandom_range(1)), 1'($urandom_range(23) == 0));
      end

      // Mid-operation reset beats a same-cycle write and pop
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++)
         apply_stimulus(1'b1, {4'h2, 10'($urandom)}, ADDR_W'($urandom), 1'b0, 1'b0);
      reset = 1'b1;
      apply_stimulus(1'b1, 14'h0777, 12'h777, 1'b1, 1'b0);
      reset = 1'b0;
      check_output("midrst_level", 32'(level),         32'd0);
      check_output("midrst_valid", 32'(bus.cmd_valid), 32'd0);
      check_output("midrst_ovf",   32'(overflow),      32'd0);
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/read_commands.md
# read_commands

Consumer end of the command-fetch pipeline: buffers commands written by the ROM-read stage (`comm_write` + ROM data + `addr_out`), raises `pause_READ` back-pressure when the buffer nears full, and presents commands in order to the execute stage over a valid/ready handshake. It also splits each command into opcode and operand fields, and halts fetch on a HALT opcode until flushed.

## Interface
- `DATA_W`, 14, command width (ROM data word)
- `ADDR_W`, 12, ROM address width (tag stored with each command)
- `OPC_W`, 4, opcode field width, taken from MSBs of the command
- `DEPTH`, 8, buffer entries; power of two, ≥ 4
- `PAUSE_LVL`, 6, fill level at or above which `pause_READ` asserts; 1 ≤ PAUSE_LVL ≤ DEPTH
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `comm_write` in 1: write strobe from the ROM-read stage
- `data_in` in DATA_W: command word, sampled when `comm_write`=1
- `addr_in` in ADDR_W: ROM address of `data_in`, sampled with it
- `flush` in 1: discard all buffered commands, leave HALTED (jump/redirect)
- `pause_READ` out 1: back-pressure to the ROM-read stage
- `cmd_valid` out 1: head command available
- `cmd_ready` in 1: execute stage accepts head
- `cmd_opcode` out OPC_W: `data_in[DATA_W-1 -: OPC_W]` of head
- `cmd_operand` out DATA_W-OPC_W: remaining low bits of head
- `cmd_addr` out ADDR_W: ROM address of head
- `level` out $clog2(DEPTH)+1: current fill count
- `overflow` out 1: sticky, a write was dropped

## Operation
- Circular buffer: `wr_ptr`, `rd_ptr` ($clog2(DEPTH) bits, wrap naturally), `level` counter 0..DEPTH.
- Push: `comm_write`=1 and (level<DEPTH, or pop in same cycle) → store {addr_in,data_in} at wr_ptr, wr_ptr+1.
- Pop: `cmd_valid`&&`cmd_ready` → rd_ptr+1.
- level_next = level + push − pop; push+pop together leaves level unchanged.
- Write with level=DEPTH and no pop: dropped, pointers unchanged, `overflow`←1.
- FSM, two states:
  - RUN: `cmd_valid` = (level≠0); `pause_READ` = (level ≥ PAUSE_LVL).
  - HALTED: `cmd_valid`=0, `pause_READ`=1; writes still accepted/dropped per above rules.
  - RUN→HALTED: pop of a head whose opcode = OPC_HALT.
  - HALTED→RUN: `flush`=1.
- `flush`: ptrs, level, `overflow` cleared; state→RUN; a same-cycle `comm_write` is discarded; a same-cycle pop has no effect.
- `cmd_opcode/operand/addr` = entry at rd_ptr; don't-care when `cmd_valid`=0.

## Timing
- Reset values: ptrs 0, level 0, state RUN, `overflow` 0, `cmd_valid` 0, `pause_READ` 0 (PAUSE_LVL≥1).
- Write at edge N into empty buffer → `cmd_valid`=1 after edge N (1-cycle latency); no bypass.
- `pause_READ`, `cmd_valid` are combinational from registered level/state only; no path from `comm_write` or `cmd_ready`.
- PAUSE_LVL = DEPTH−2 leaves two slots for writes in flight from the ROM-read stage.
- Reset overrides flush, push, pop; mid-operation reset empties the buffer next edge.
- `cmd_ready` may toggle freely; head is held stable while `cmd_valid`=1 and not popped.

## Structure
- Shared package `cpu_pkg`: OPC_W, opcode localparams incl. OPC_HALT = 4'hF, command field slicing helpers.
- Sub-module `cmd_buf_mem`: DEPTH × (ADDR_W+DATA_W) register array, one write port, one async read port; pointers/level/FSM stay in `read_commands`.

## Test plan
- Reset, then write 0x1ABC@addr 0x010 → next cycle `cmd_valid`=1, opcode 0x6, operand 0x2BC, `cmd_addr` 0x010; ready=1 pops, level 0.
- Write 6 commands, ready=0 → `pause_READ`=1 exactly after 6th write (level 6); pop one → `pause_READ`=0.
- Fill to 8, write 9th without pop → dropped, `overflow`=1, level 8; 9th write with simultaneous pop → accepted, level 8.
- Queue 0x3C05 (HALT) followed by 0x0001, pop HALT → `cmd_valid`=0, `pause_READ`=1 with level 1; `flush` → level 0, RUN, overflow 0.
- 20 write/pop pairs across pointer wrap with ready toggling → output order and addr tags match input order exactly.
- `flush` and `comm_write` same cycle at level 3 → level 0 next cycle, written word never appears.
